multicycle_control_fsm: RTL and testbench

Multi-cycle successor to the single-cycle ControlUnit for the RV32I core. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and waits on a memory-ready handshake. It traps on illegal opcodes and memory timeouts. ALUOp encoding is unchanged (00 add, 01 branch compare, 10 funct decode), so the existing ALU control is reused.

---
 rtl/multicycle_control_fsm.sv | 245 ++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXECUTE/MEM/WB sequencing,
// a memory-ready handshake with a bus timeout, and sticky illegal-opcode and
// bus-error traps. ALUOp keeps the single-cycle encoding (00 add, 01 branch,
// 10 funct) so the existing ALU control decoder is reused unchanged.
// Optional build macro CTRL_JUMP_EN adds JAL, JALR, LUI and AUIPC handling.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] MemToReg,
  output logic       RegWrite,
  output logic       Branch,
  output logic       InstrDone,
  output logic       IllegalInstr,
  output logic       BusError,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_WB_ALU   = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_WB_MEM   = 4'd7;
  localparam logic [3:0] S_MEM_WR   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_TRAP     = 4'd10;
`ifdef CTRL_JUMP_EN
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_JALR     = 4'd12;
  localparam logic [3:0] S_EXEC_U   = 4'd13;
`endif

  // A zero timeout means wait forever; the compare value is then irrelevant.
  localparam bit              TO_EN   = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [3:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ill_flag, bus_flag;
  logic             ill_set, bus_set;
  // opcode[5] latched in DECODE: separates store/load and LUI/AUIPC later on.
  logic             op_b5;

  // Wait-state timeout check shared by FETCH, MEM_RD and MEM_WR.
  logic             timeout_hit;
  assign timeout_hit = TO_EN && !mem_ready && (cnt == TO_LAST);

  // Next-state, timeout counter and trap-flag set decisions.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ill_set  = 1'b0;
    bus_set  = 1'b0;
    case (state)
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) begin
          if (state == S_FETCH)       state_nx = S_DECODE;
          else if (state == S_MEM_RD) state_nx = S_WB_MEM;
          else                        state_nx = S_FETCH;
        end else if (timeout_hit) begin
          state_nx = S_TRAP;
          bus_set  = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          7'b0110011: state_nx = S_EXEC_R;
          7'b0010011: state_nx = S_EXEC_I;
          7'b0000011,
          7'b0100011: state_nx = S_MEM_ADDR;
          7'b1100011: state_nx = S_BRANCH;
`ifdef CTRL_JUMP_EN
          7'b1101111: state_nx = S_JAL;
          7'b1100111: state_nx = S_JALR;
          7'b0110111,
          7'b0010111: state_nx = S_EXEC_U;
`endif
          default: begin
            state_nx = S_TRAP;
            ill_set  = 1'b1;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I:     state_nx = S_WB_ALU;
      S_MEM_ADDR:             state_nx = op_b5 ? S_MEM_WR : S_MEM_RD;
      S_WB_ALU, S_WB_MEM,
      S_BRANCH:               state_nx = S_FETCH;
`ifdef CTRL_JUMP_EN
      S_JAL, S_JALR:          state_nx = S_FETCH;
      S_EXEC_U:               state_nx = S_WB_ALU;
`endif
      S_TRAP:                 state_nx = S_TRAP;
      default:                state_nx = S_TRAP;
    endcase
    // Every wait state starts counting from zero.
    if (state_nx != state) cnt_nx = '0;
  end

  // State register, counter and sticky trap flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      cnt      <= '0;
      ill_flag <= 1'b0;
      bus_flag <= 1'b0;
      op_b5    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (ill_set) ill_flag <= 1'b1;
      if (bus_set) bus_flag <= 1'b1;
      if (state == S_DECODE) op_b5 <= opcode[5];
    end
  end

  // Per-state control decode; reset forces every output low.
  always_comb begin
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    MemToReg  = 2'b00;
    RegWrite  = 1'b0;
    Branch    = 1'b0;
    InstrDone = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b01;
        ALUOp   = 2'b10;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b10;
      end
      S_WB_ALU: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_WB_MEM: begin
        RegWrite  = 1'b1;
        MemToReg  = 2'b01;
        InstrDone = 1'b1;
      end
      S_MEM_WR: begin
        IorD      = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = mem_ready;
      end
      S_BRANCH: begin
        ALUSrcA   = 2'b01;
        ALUOp     = 2'b01;
        Branch    = 1'b1;
        PCSrc     = 2'b01;
        PCWrite   = branch_taken;
        InstrDone = 1'b1;
      end
`ifdef CTRL_JUMP_EN
      S_JAL: begin
        PCWrite   = 1'b1;
        PCSrc     = 2'b01;
        RegWrite  = 1'b1;
        MemToReg  = 2'b10;
        InstrDone = 1'b1;
      end
      S_JALR: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        PCSrc     = 2'b10;
        PCWrite   = 1'b1;
        RegWrite  = 1'b1;
        MemToReg  = 2'b10;
        InstrDone = 1'b1;
      end
      S_EXEC_U: begin
        ALUSrcA = op_b5 ? 2'b11 : 2'b10;
        ALUSrcB = 2'b10;
      end
`endif
      default: ;
    endcase
    if (rst) begin
      IorD      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCSrc     = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      MemToReg  = 2'b00;
      RegWrite  = 1'b0;
      Branch    = 1'b0;
      InstrDone = 1'b0;
    end
  end

  assign IllegalInstr = ill_flag & ~rst;
  assign BusError     = bus_flag & ~rst;
  assign state_o      = rst ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (MEM_TIMEOUT=16). Inputs change on
// the falling edge; outputs are sampled 1ns later, mid-cycle.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       mem_ready, branch_taken;
  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite;
  logic [1:0] PCSrc, ALUSrcA, ALUSrcB, ALUOp, MemToReg;
  logic       RegWrite, Branch, InstrDone, IllegalInstr, BusError;
  logic [3:0] state_o;
  logic [19:0] obs;

  int vectors = 0;
  int errs    = 0;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  multicycle_control_fsm #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .Branch(Branch), .InstrDone(InstrDone),
    .IllegalInstr(IllegalInstr), .BusError(BusError), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign obs = {IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA,
                ALUSrcB, ALUOp, MemToReg, RegWrite, Branch, InstrDone,
                IllegalInstr, BusError};

  // Expected control word, written field by field in the same order as obs.
  function automatic logic [19:0] pk(
    input logic iord, mr, mw, irw, pcw,
    input logic [1:0] pcsrc, asa, asb, aop, m2r,
    input logic rw, br, done, ill, bus);
    return {iord, mr, mw, irw, pcw, pcsrc, asa, asb, aop, m2r, rw, br, done, ill, bus};
  endfunction

  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] req);
    vectors++;
    assert (got === req) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, req);
    end
  endtask

  // Apply one cycle of inputs, then check state and the full control word.
  task automatic step(input string tag, input logic r, input logic [6:0] op,
                      input logic rdy, input logic bt,
                      input logic [3:0] st, input logic [19:0] req);
    @(negedge clk);
    rst = r; opcode = op; mem_ready = rdy; branch_taken = bt;
    #1;
    chk({tag, ".state"}, {16'd0, state_o}, {16'd0, st});
    chk({tag, ".ctl"}, obs, req);
  endtask

  logic [19:0] z, f_rdy, f_wait, dec, trap_ill, trap_bus;

  initial begin
    z        = pk(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0);
    f_rdy    = pk(0,1,0,1,1, 2'b00,2'b00,2'b01,2'b00,2'b00, 0,0,0,0,0);
    f_wait   = pk(0,1,0,0,0, 2'b00,2'b00,2'b01,2'b00,2'b00, 0,0,0,0,0);
    dec      = pk(0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00,2'b00, 0,0,0,0,0);
    trap_ill = pk(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,1,0);
    trap_bus = pk(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0,1);
    rst = 1'b1; opcode = OP_R; mem_ready = 1'b1; branch_taken = 1'b1;

    // Reset: outputs forced low even though FETCH with ready would pulse IRWrite.
    step("rst0", 1, OP_R, 1, 1, 4'd0, z);
    step("rst1", 1, OP_R, 1, 1, 4'd0, z);

    // R-type, no wait states: 4 cycles.
    step("r.fetch", 0, OP_R, 1, 0, 4'd0, f_rdy);
    step("r.dec",   0, OP_R, 1, 0, 4'd1, dec);
    step("r.exec",  0, OP_R, 1, 0, 4'd2, pk(0,0,0,0,0, 2'b00,2'b01,2'b00,2'b10,2'b00, 0,0,0,0,0));
    step("r.wb",    0, OP_R, 1, 0, 4'd4, pk(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 1,0,1,0,0));

    // Load with 3 wait cycles in MEM_RD.
    step("ld.fetch", 0, OP_LD, 1, 0, 4'd0, f_rdy);
    step("ld.dec",   0, OP_LD, 0, 0, 4'd1, dec);
    step("ld.addr",  0, OP_LD, 0, 0, 4'd5, pk(0,0,0,0,0, 2'b00,2'b01,2'b10,2'b00,2'b00, 0,0,0,0,0));
    for (int i = 0; i < 3; i++)
      step("ld.wait", 0, OP_LD, 0, 0, 4'd6, pk(1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0));
    step("ld.rdy",   0, OP_LD, 1, 0, 4'd6, pk(1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0));
    step("ld.wb",    0, OP_LD, 1, 0, 4'd7, pk(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01, 1,0,1,0,0));

    // Store: 4 cycles, MemWrite, never RegWrite.
    step("st.fetch", 0, OP_ST, 1, 0, 4'd0, f_rdy);
    step("st.dec",   0, OP_ST, 1, 0, 4'd1, dec);
    step("st.addr",  0, OP_ST, 1, 0, 4'd5, pk(0,0,0,0,0, 2'b00,2'b01,2'b10,2'b00,2'b00, 0,0,0,0,0));
    step("st.wr",    0, OP_ST, 1, 0, 4'd8, pk(1,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,1,0,0));

    // Branch taken then not taken: 3 cycles each.
    step("bt.fetch", 0, OP_BR, 1, 1, 4'd0, f_rdy);
    step("bt.dec",   0, OP_BR, 1, 1, 4'd1, dec);
    step("bt.br",    0, OP_BR, 1, 1, 4'd9, pk(0,0,0,0,1, 2'b01,2'b01,2'b00,2'b01,2'b00, 0,1,1,0,0));
    step("bn.fetch", 0, OP_BR, 1, 0, 4'd0, f_rdy);
    step("bn.dec",   0, OP_BR, 1, 0, 4'd1, dec);
    step("bn.br",    0, OP_BR, 1, 0, 4'd9, pk(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b01,2'b00, 0,1,1,0,0));
    step("bn.next",  0, OP_BR, 0, 0, 4'd0, f_wait);

    // JAL: a 3-cycle jump when enabled, otherwise an illegal opcode.
    step("jal.fetch", 0, OP_JAL, 1, 0, 4'd0, f_rdy);
    step("jal.dec",   0, OP_JAL, 1, 0, 4'd1, dec);
`ifdef CTRL_JUMP_EN
    step("jal.exec",  0, OP_JAL, 1, 0, 4'd11, pk(0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,2'b10, 1,0,1,0,0));
    step("jal.next",  0, OP_BAD, 1, 0, 4'd0, f_rdy);
`else
    step("jal.trap",  0, OP_JAL, 1, 0, 4'd10, trap_ill);
    step("jal.rst",   1, OP_BAD, 1, 0, 4'd0, z);
    step("jal.clr",   0, OP_BAD, 1, 0, 4'd0, f_rdy);
`endif

    // Illegal opcode: TRAP holds with only IllegalInstr high, left only by rst.
    step("ill.dec", 0, OP_BAD, 1, 1, 4'd1, dec);
    for (int i = 0; i < 12; i++)
      step("ill.trap", 0, OP_BAD, 1, 1, 4'd10, trap_ill);
    step("ill.rst", 1, OP_BAD, 1, 1, 4'd0, z);

    // Timeout: 16 FETCH cycles without ready, then TRAP with BusError.
    for (int i = 0; i < 16; i++)
      step("to.wait", 0, OP_R, 0, 0, 4'd0, f_wait);
    step("to.trap",  0, OP_R, 0, 0, 4'd10, trap_bus);
    step("to.hold",  0, OP_R, 1, 0, 4'd10, trap_bus);
    step("to.rst",   1, OP_R, 0, 0, 4'd0, z);

    // Ready on the 16th cycle wins over the timeout.
    for (int i = 0; i < 15; i++)
      step("rw.wait", 0, OP_R, 0, 0, 4'd0, f_wait);
    step("rw.rdy",  0, OP_R, 1, 0, 4'd0, f_rdy);
    step("rw.dec",  0, OP_R, 1, 0, 4'd1, dec);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
